// File: rtl/demux_latch.sv
// One-to-eight registered distributor: latches a bus value into the slot picked by s and flags it valid until acked.
// Latency: 1 cycle from accepted transfer to visible d_k/vld[k]; in_ready is combinational from vld, s and ack.
// Backpressure: in_ready drops while the addressed slot is full and not being acked this cycle; stalled cycles are counted.
module demux_latch #(
   parameter int width = 3,
   parameter int DW    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [width-1:0] s,
   input  logic [DW-1:0]    data_i,
   output logic [DW-1:0]    d0,
   output logic [DW-1:0]    d1,
   output logic [DW-1:0]    d2,
   output logic [DW-1:0]    d3,
   output logic [DW-1:0]    d4,
   output logic [DW-1:0]    d5,
   output logic [DW-1:0]    d6,
   output logic [DW-1:0]    d7,
   output logic [7:0]       vld,
   input  logic [7:0]       ack,
   output logic [7:0]       stall_cnt
);

   // Slots at or above NSLOT cannot be addressed and stay empty forever.
   localparam int NSLOT = 1 << width;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_t;

   slot_state_t   state_q [8];
   slot_state_t   state_d [8];
   logic [DW-1:0] data_q  [8];
   logic [2:0]    sel;
   logic [7:0]    wr;
   logic          accept;
   logic          stall;

   assign sel = 3'(s);

   // Valid flags are a direct decode of the per-slot state.
   always_comb begin
      vld = '0;
      for (int k = 0; k < 8; k++) begin
         vld[k] = (state_q[k] == FULL);
      end
   end

   // An ack on the addressed slot frees it in the same cycle, so a full slot can be refilled without a bubble.
   assign in_ready = ~vld[sel] | ack[sel];
   assign accept   = in_valid & in_ready;
   assign stall    = in_valid & ~in_ready;

   // One-hot write strobe for the addressed slot on an accepted transfer.
   always_comb begin
      wr = '0;
      for (int k = 0; k < 8; k++) begin
         if (accept && (sel == 3'(k)) && (k < NSLOT)) begin
            wr[k] = 1'b1;
         end
      end
   end

   // Per-slot next state: write fills, ack without a write empties, empty slots ignore ack.
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         state_d[k] = state_q[k];
         case (state_q[k])
            EMPTY: if (wr[k]) state_d[k] = FULL;
            FULL:  if (ack[k] && !wr[k]) state_d[k] = EMPTY;
            default: state_d[k] = EMPTY;
         endcase
         if (k >= NSLOT) begin
            state_d[k] = EMPTY;
         end
      end
   end

   // Slot state register; reset discards any held data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 8; k++) begin
            state_q[k] <= EMPTY;
         end
      end else begin
         for (int k = 0; k < 8; k++) begin
            state_q[k] <= state_d[k];
         end
      end
   end

   // Holding registers load only on their own write strobe and keep their value after consumption.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 8; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 8; k++) begin
            if (wr[k]) begin
               data_q[k] <= data_i;
            end
         end
      end
   end

   // Saturating debug counter of cycles where the producer was held off.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != 8'hFF)) begin
         stall_cnt <= stall_cnt + 8'd1;
      end
   end

   assign d0 = data_q[0];
   assign d1 = data_q[1];
   assign d2 = data_q[2];
   assign d3 = data_q[3];
   assign d4 = data_q[4];
   assign d5 = data_q[5];
   assign d6 = data_q[6];
   assign d7 = data_q[7];

endmodule

// File: tb/tb_demux_latch.sv
// Directed bench for demux_latch: a width=3 instance for the main table and corner cases, a width=1 instance for inactive slots.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Summary line reports comparisons made and miscompares.
module tb_demux_latch;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   // width=3 instance
   logic        a_iv = 1'b0;
   logic        a_rdy;
   logic [2:0]  a_s = '0;
   logic [31:0] a_dat = '0;
   wire  [31:0] a_d [8];
   logic [7:0]  a_vld;
   logic [7:0]  a_ack = '0;
   logic [7:0]  a_stall;

   // width=1 instance
   logic        b_iv = 1'b0;
   logic        b_rdy;
   logic [0:0]  b_s = '0;
   logic [31:0] b_dat = '0;
   wire  [31:0] b_d [8];
   logic [7:0]  b_vld;
   logic [7:0]  b_ack = '0;
   logic [7:0]  b_stall;

   demux_latch #(.width(3), .DW(32)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_rdy), .s(a_s), .data_i(a_dat),
      .d0(a_d[0]), .d1(a_d[1]), .d2(a_d[2]), .d3(a_d[3]),
      .d4(a_d[4]), .d5(a_d[5]), .d6(a_d[6]), .d7(a_d[7]),
      .vld(a_vld), .ack(a_ack), .stall_cnt(a_stall)
   );

   demux_latch #(.width(1), .DW(32)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_rdy), .s(b_s), .data_i(b_dat),
      .d0(b_d[0]), .d1(b_d[1]), .d2(b_d[2]), .d3(b_d[3]),
      .d4(b_d[4]), .d5(b_d[5]), .d6(b_d[6]), .d7(b_d[7]),
      .vld(b_vld), .ack(b_ack), .stall_cnt(b_stall)
   );

   typedef struct {
      logic        iv;
      logic [2:0]  s;
      logic [31:0] dat;
      logic [7:0]  ack;
      logic        exp_rdy;
      logic [7:0]  exp_vld;
      logic [2:0]  chk_slot;
      logic [31:0] exp_d;
      logic [7:0]  exp_stall;
   } vec_t;

   localparam int NV = 14;
   vec_t vt [NV];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      //          iv    s     dat            ack    rdy   vld    slot  d              stall
      vt[0]  = '{1'b1, 3'd5, 32'hDEADBEEF, 8'h00, 1'b1, 8'h20, 3'd5, 32'hDEADBEEF, 8'd0};
      vt[1]  = '{1'b0, 3'd0, 32'h0,        8'h20, 1'b1, 8'h00, 3'd5, 32'hDEADBEEF, 8'd0};
      vt[2]  = '{1'b0, 3'd0, 32'h0,        8'h00, 1'b1, 8'h00, 3'd0, 32'h0,        8'd0};
      vt[3]  = '{1'b1, 3'd2, 32'h77,       8'h00, 1'b1, 8'h04, 3'd2, 32'h77,       8'd0};
      vt[4]  = '{1'b1, 3'd2, 32'h1,        8'h00, 1'b0, 8'h04, 3'd2, 32'h77,       8'd1};
      vt[5]  = '{1'b1, 3'd2, 32'h1,        8'h00, 1'b0, 8'h04, 3'd2, 32'h77,       8'd2};
      vt[6]  = '{1'b1, 3'd2, 32'h1,        8'h00, 1'b0, 8'h04, 3'd2, 32'h77,       8'd3};
      vt[7]  = '{1'b1, 3'd2, 32'h1,        8'h04, 1'b1, 8'h04, 3'd2, 32'h1,        8'd3};
      vt[8]  = '{1'b1, 3'd3, 32'h33,       8'h00, 1'b1, 8'h0C, 3'd3, 32'h33,       8'd3};
      vt[9]  = '{1'b1, 3'd0, 32'hA,        8'h08, 1'b1, 8'h05, 3'd0, 32'hA,        8'd3};
      vt[10] = '{1'b0, 3'd4, 32'h0,        8'h10, 1'b1, 8'h05, 3'd3, 32'h33,       8'd3};
      vt[11] = '{1'b0, 3'd0, 32'h0,        8'h05, 1'b1, 8'h00, 3'd0, 32'hA,        8'd3};
      vt[12] = '{1'b1, 3'd7, 32'hFFFF0000, 8'h80, 1'b1, 8'h80, 3'd7, 32'hFFFF0000, 8'd3};
      vt[13] = '{1'b0, 3'd0, 32'h0,        8'h00, 1'b1, 8'h80, 3'd5, 32'hDEADBEEF, 8'd3};

      // Reset state, before any clock edge.
      #2;
      chk("reset_vld", 32'(a_vld), 32'h0);
      chk("reset_stall", 32'(a_stall), 32'h0);
      for (int k = 0; k < 8; k++) chk($sformatf("reset_d%0d", k), a_d[k], 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Main table on the width=3 instance.
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         a_iv  = vt[i].iv;
         a_s   = vt[i].s;
         a_dat = vt[i].dat;
         a_ack = vt[i].ack;
         #1;
         chk($sformatf("v%0d_rdy", i), 32'(a_rdy), 32'(vt[i].exp_rdy));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_vld", i), 32'(a_vld), 32'(vt[i].exp_vld));
         chk($sformatf("v%0d_d%0d", i, vt[i].chk_slot), a_d[vt[i].chk_slot], vt[i].exp_d);
         chk($sformatf("v%0d_stall", i), 32'(a_stall), 32'(vt[i].exp_stall));
      end

      // Asynchronous reset in the middle of a cycle while data is held.
      @(negedge clk);
      a_iv  = 1'b0;
      a_ack = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("areset_vld", 32'(a_vld), 32'h0);
      chk("areset_stall", 32'(a_stall), 32'h0);
      for (int k = 0; k < 8; k++) chk($sformatf("areset_d%0d", k), a_d[k], 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Saturation: fill slot 6, then hold a blocked write for 300 cycles.
      @(negedge clk);
      a_iv  = 1'b1;
      a_s   = 3'd6;
      a_dat = 32'h5;
      @(posedge clk);
      #1;
      chk("sat_fill_vld", 32'(a_vld), 32'h40);
      chk("sat_fill_stall", 32'(a_stall), 32'h0);
      repeat (254) @(posedge clk);
      #1;
      chk("sat_254", 32'(a_stall), 32'd254);
      @(posedge clk);
      #1;
      chk("sat_255", 32'(a_stall), 32'd255);
      repeat (45) @(posedge clk);
      #1;
      chk("sat_hold", 32'(a_stall), 32'd255);
      chk("sat_rdy", 32'(a_rdy), 32'h0);
      chk("sat_d6", a_d[6], 32'h5);

      // width=1 instance: only slots 0 and 1 exist.
      @(negedge clk);
      a_iv  = 1'b0;
      b_iv  = 1'b1;
      b_s   = 1'b1;
      b_dat = 32'h55;
      #1;
      chk("w1_rdy", 32'(b_rdy), 32'h1);
      @(posedge clk);
      #1;
      chk("w1_d1", b_d[1], 32'h55);
      chk("w1_vld", 32'(b_vld), 32'h02);
      @(negedge clk);
      b_iv  = 1'b0;
      b_ack = 8'hFC;
      @(posedge clk);
      #1;
      chk("w1_ackhi_vld", 32'(b_vld), 32'h02);
      chk("w1_ackhi_d1", b_d[1], 32'h55);
      for (int k = 2; k < 8; k++) chk($sformatf("w1_d%0d", k), b_d[k], 32'h0);
      @(negedge clk);
      b_ack = 8'h00;
      b_iv  = 1'b1;
      b_s   = 1'b1;
      b_dat = 32'h66;
      #1;
      chk("w1_blk_rdy", 32'(b_rdy), 32'h0);
      @(posedge clk);
      #1;
      chk("w1_blk_stall", 32'(b_stall), 32'd1);
      chk("w1_blk_d1", b_d[1], 32'h55);
      @(negedge clk);
      b_ack = 8'h02;
      @(posedge clk);
      #1;
      chk("w1_pass_d1", b_d[1], 32'h66);
      chk("w1_pass_vld", 32'(b_vld), 32'h02);
      @(negedge clk);
      b_iv  = 1'b1;
      b_s   = 1'b0;
      b_dat = 32'h99;
      b_ack = 8'h02;
      @(posedge clk);
      #1;
      chk("w1_s0_d0", b_d[0], 32'h99);
      chk("w1_s0_vld", 32'(b_vld), 32'h01);
      @(negedge clk);
      b_iv  = 1'b0;
      b_ack = 8'h00;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
